// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 divider: FSM state encoding,
// exponent limits, special encodings and the unpacked-float record.
package fp_pkg;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SPECIAL,
    NORM_A,
    NORM_B,
    DIV_INIT,
    DIV_ITER,
    DIV_DONE,
    NORM_1,
    NORM_2,
    ROUND,
    PACK,
    PUT_Z
  } fp_state_e;

  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_MIN  = -10'sd126;
  localparam logic signed [9:0] EXP_MAX  = 10'sd127;

  localparam logic [31:0] QNAN    = 32'hFFC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef struct packed {
    logic              sign;
    logic signed [9:0] exponent;
    logic [23:0]       mantissa;
  } fp_unpacked_t;

  // Hidden bit is left clear here; it is set later once zero/denormal is known.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign     = x[31];
    u.exponent = $signed({2'b00, x[30:23]}) - EXP_BIAS;
    u.mantissa = {1'b0, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_mant_div.sv
// Iterative radix-2 restoring divider: q = floor((a_m << 26) / b_m), 27 bits,
// MSB first. The start cycle already performs the first of the 27 iterations.
module fp_mant_div
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] a_m,
  input  logic [23:0] b_m,
  output logic [26:0] q,
  output logic        rem_nz,
  output logic        done
);

  localparam logic [4:0] LAST_ITER = 5'd26;

  logic [24:0] rem_q, rem_d;
  logic [26:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic [24:0] step_in, step_out;
  logic [26:0] q_base;
  logic        ge;

  always_comb begin
    step_in  = start ? {1'b0, a_m} : rem_q;
    q_base   = start ? 27'd0 : q_q;
    ge       = (step_in >= {1'b0, b_m});
    step_out = ge ? (step_in - {1'b0, b_m}) : step_in;

    rem_d  = rem_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (start) begin
      rem_d  = step_out << 1;
      q_d    = (q_base << 1) | 27'(ge);
      cnt_d  = 5'd1;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_out << 1;
      q_d   = (q_base << 1) | 27'(ge);
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST_ITER) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // High during the cycle that performs the final iteration.
  assign done   = busy_q && (cnt_q == LAST_ITER);
  assign q      = q_q;
  assign rem_nz = (rem_q != '0);

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 binary32 divider z = a / b, multi-cycle, round-to-nearest-even.
// Define FP_DIV_DENORM_EN for gradual underflow; otherwise denormals flush to zero.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  // Handshake: a word moves on any rising edge where stb (producer valid) and
  // ack (consumer ready) are both high; stb and its data hold until then.
  fp_state_e state_q, state_d;

  logic [31:0]       a_raw_q, a_raw_d, b_raw_q, b_raw_d;
  fp_unpacked_t      a_q, a_d, b_q, b_d;
  logic              z_s_q, z_s_d;
  logic signed [9:0] z_e_q, z_e_d;
  logic [23:0]       z_m_q, z_m_d;
  logic              guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic              input_a_ack_q, input_a_ack_d, input_b_ack_q, input_b_ack_d;
  logic              output_z_stb_q, output_z_stb_d;
  logic [31:0]       output_z_q, output_z_d;

  logic        div_start, div_rem_nz, div_done;
  logic [26:0] div_q;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_xor;
  logic [7:0]  pack_exp;

  fp_mant_div u_mant_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (div_start),
    .a_m    (a_q.mantissa),
    .b_m    (b_q.mantissa),
    .q      (div_q),
    .rem_nz (div_rem_nz),
    .done   (div_done)
  );

  assign div_start = (state_q == DIV_INIT);
  assign s_xor     = a_q.sign ^ b_q.sign;
  assign pack_exp  = 8'(z_e_q + EXP_BIAS);

  assign a_nan = (a_q.exponent == 10'sd128) && (a_q.mantissa != '0);
  assign b_nan = (b_q.exponent == 10'sd128) && (b_q.mantissa != '0);
  assign a_inf = (a_q.exponent == 10'sd128) && (a_q.mantissa == '0);
  assign b_inf = (b_q.exponent == 10'sd128) && (b_q.mantissa == '0);
`ifdef FP_DIV_DENORM_EN
  assign a_zero = (a_q.exponent == -10'sd127) && (a_q.mantissa == '0);
  assign b_zero = (b_q.exponent == -10'sd127) && (b_q.mantissa == '0);
`else
  assign a_zero = (a_q.exponent == -10'sd127);
  assign b_zero = (b_q.exponent == -10'sd127);
`endif

  always_comb begin
    state_d        = state_q;
    a_raw_d        = a_raw_q;
    b_raw_d        = b_raw_q;
    a_d            = a_q;
    b_d            = b_q;
    z_s_d          = z_s_q;
    z_e_d          = z_e_q;
    z_m_d          = z_m_q;
    guard_d        = guard_q;
    round_d        = round_q;
    sticky_d       = sticky_q;
    input_a_ack_d  = input_a_ack_q;
    input_b_ack_d  = input_b_ack_q;
    output_z_stb_d = output_z_stb_q;
    output_z_d     = output_z_q;

    case (state_q)
      GET_A: begin
        if (input_a_ack_q && input_a_stb) begin
          a_raw_d       = input_a;
          input_a_ack_d = 1'b0;
          state_d       = GET_B;
        end else begin
          input_a_ack_d = 1'b1;
        end
      end
      GET_B: begin
        if (input_b_ack_q && input_b_stb) begin
          b_raw_d       = input_b;
          input_b_ack_d = 1'b0;
          state_d       = UNPACK;
        end else begin
          input_b_ack_d = 1'b1;
        end
      end
      UNPACK: begin
        a_d     = fp_unpack(a_raw_q);
        b_d     = fp_unpack(b_raw_q);
        state_d = SPECIAL;
      end
      SPECIAL: begin
        state_d = PUT_Z;
        if (a_nan || b_nan || (a_inf && b_inf)) begin
          output_z_d = QNAN;
        end else if (a_inf) begin
          output_z_d = {s_xor, POS_INF[30:0]};
        end else if (b_inf) begin
          output_z_d = {s_xor, 31'd0};
        end else if (b_zero) begin
          output_z_d = a_zero ? QNAN : {s_xor, POS_INF[30:0]};
        end else if (a_zero) begin
          output_z_d = {s_xor, 31'd0};
        end else begin
          // Denormals keep a clear hidden bit and take the minimum exponent.
          if (a_q.exponent == -10'sd127) a_d.exponent = EXP_MIN;
          else                           a_d.mantissa[23] = 1'b1;
          if (b_q.exponent == -10'sd127) b_d.exponent = EXP_MIN;
          else                           b_d.mantissa[23] = 1'b1;
          state_d = NORM_A;
        end
      end
      NORM_A: begin
        if (a_q.mantissa[23]) begin
          state_d = NORM_B;
        end else begin
          a_d.mantissa = a_q.mantissa << 1;
          a_d.exponent = a_q.exponent - 10'sd1;
        end
      end
      NORM_B: begin
        if (b_q.mantissa[23]) begin
          state_d = DIV_INIT;
        end else begin
          b_d.mantissa = b_q.mantissa << 1;
          b_d.exponent = b_q.exponent - 10'sd1;
        end
      end
      DIV_INIT: begin
        z_s_d   = s_xor;
        z_e_d   = a_q.exponent - b_q.exponent;
        state_d = DIV_ITER;
      end
      DIV_ITER: begin
        if (div_done) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        z_m_d    = div_q[26:3];
        guard_d  = div_q[2];
        round_d  = div_q[1];
        sticky_d = div_q[0] | div_rem_nz;
        state_d  = NORM_1;
      end
      NORM_1: begin
        if (z_m_q[23]) begin
          state_d = NORM_2;
        end else begin
          z_m_d   = {z_m_q[22:0], guard_q};
          guard_d = round_q;
          round_d = 1'b0;
          z_e_d   = z_e_q - 10'sd1;
        end
      end
      NORM_2: begin
`ifdef FP_DIV_DENORM_EN
        if (z_e_q < EXP_MIN) begin
          z_m_d    = z_m_q >> 1;
          z_e_d    = z_e_q + 10'sd1;
          guard_d  = z_m_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
        end else begin
          state_d = ROUND;
        end
`else
        // Results below the normal range collapse to a signed zero.
        if (z_e_q < EXP_MIN) begin
          z_m_d    = '0;
          z_e_d    = EXP_MIN;
          guard_d  = 1'b0;
          round_d  = 1'b0;
          sticky_d = 1'b0;
        end
        state_d = ROUND;
`endif
      end
      ROUND: begin
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFFFFFF) begin
            z_m_d = 24'h800000;
            z_e_d = z_e_q + 10'sd1;
          end
        end
        state_d = PACK;
      end
      PACK: begin
        output_z_d = {z_s_q, pack_exp, z_m_q[22:0]};
        if ((z_e_q == EXP_MIN) && !z_m_q[23]) output_z_d[30:23] = 8'd0;
        if (z_e_q > EXP_MAX) output_z_d = {z_s_q, POS_INF[30:0]};
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (output_z_stb_q && output_z_ack) begin
          output_z_stb_d = 1'b0;
          state_d        = GET_A;
        end else begin
          output_z_stb_d = 1'b1;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= GET_A;
      a_raw_q        <= '0;
      b_raw_q        <= '0;
      a_q            <= '0;
      b_q            <= '0;
      z_s_q          <= 1'b0;
      z_e_q          <= '0;
      z_m_q          <= '0;
      guard_q        <= 1'b0;
      round_q        <= 1'b0;
      sticky_q       <= 1'b0;
      input_a_ack_q  <= 1'b0;
      input_b_ack_q  <= 1'b0;
      output_z_stb_q <= 1'b0;
      output_z_q     <= '0;
    end else begin
      state_q        <= state_d;
      a_raw_q        <= a_raw_d;
      b_raw_q        <= b_raw_d;
      a_q            <= a_d;
      b_q            <= b_d;
      z_s_q          <= z_s_d;
      z_e_q          <= z_e_d;
      z_m_q          <= z_m_d;
      guard_q        <= guard_d;
      round_q        <= round_d;
      sticky_q       <= sticky_d;
      input_a_ack_q  <= input_a_ack_d;
      input_b_ack_q  <= input_b_ack_d;
      output_z_stb_q <= output_z_stb_d;
      output_z_q     <= output_z_d;
    end
  end

  assign input_a_ack  = input_a_ack_q;
  assign input_b_ack  = input_b_ack_q;
  assign output_z_stb = output_z_stb_q;
  assign output_z     = output_z_q;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: vector table, handshake stall/backpressure
// sequences and a mid-division reset, with an expected-result queue.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] input_b = '0;
  logic        input_b_stb = 1'b0;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
  } vec_t;

  fp_divider dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Driver tasks: entered and left at a falling edge.
  task automatic drive_a(input logic [31:0] a);
    int n = 0;
    input_a     = a;
    input_a_stb = 1'b1;
    while (!input_a_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!input_a_ack) begin
      checks++;
      errors++;
      $display("FAIL a_accept: got no input_a_ack, expected ack within 200 cycles");
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    input_a_stb = 1'b0;
  endtask

  task automatic drive_b(input logic [31:0] b, output int b_edge);
    int n = 0;
    input_b     = b;
    input_b_stb = 1'b1;
    while (!input_b_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!input_b_ack) begin
      checks++;
      errors++;
      $display("FAIL b_accept: got no input_b_ack, expected ack within 200 cycles");
    end else begin
      @(posedge clk);
    end
    #1;
    b_edge = cycle;
    @(negedge clk);
    input_b_stb = 1'b0;
  endtask

  // Scoreboard side: wait for z, check latency and value, optionally stall the ack.
  task automatic wait_result(input string name, input int b_edge, input int exp_lat, input int hold);
    int          n = 0;
    int          bad = 0;
    logic [31:0] exp_z;
    while (!output_z_stb && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!output_z_stb) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no output_z_stb, expected one within 400 cycles", name);
      if (exp_q.size() != 0) exp_z = exp_q.pop_front();
      return;
    end
    if (exp_lat >= 0) check_int({name, "_latency"}, cycle - b_edge, exp_lat);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got z=%h, expected no output", name, output_z);
      return;
    end
    exp_z = exp_q.pop_front();
    check(name, output_z, exp_z);
    if (hold > 0) begin
      input_a     = 32'hDEADBEEF;
      input_a_stb = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (output_z !== exp_z || !output_z_stb || input_a_ack) bad++;
      end
      input_a_stb = 1'b0;
      check_int({name, "_hold_bad_cycles"}, bad, 0);
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    check({name, "_stb_drop"}, {31'd0, output_z_stb}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z, input int lat, input int hold);
    int be;
    exp_q.push_back(z);
    drive_a(a);
    drive_b(b, be);
    wait_result(name, be, lat, hold);
  endtask

  initial begin
    vec_t vecs[18];
    int   be;
    int   bad;

    vecs[0]  = '{"div_6_2",       32'h40C00000, 32'h40000000, 32'h40400000, 37};
    vecs[1]  = '{"div_1_3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 38};
    vecs[2]  = '{"one_by_zero",   32'h3F800000, 32'h00000000, 32'h7F800000, 3};
    vecs[3]  = '{"zero_by_zero",  32'h00000000, 32'h00000000, 32'hFFC00000, 3};
    vecs[4]  = '{"ninf_by_2",     32'hFF800000, 32'h40000000, 32'hFF800000, 3};
    vecs[5]  = '{"two_by_inf",    32'h40000000, 32'h7F800000, 32'h00000000, 3};
    vecs[6]  = '{"overflow",      32'h7F000000, 32'h00800000, 32'h7F800000, 37};
    vecs[8]  = '{"nan_a",         32'h7FC00000, 32'h3F800000, 32'hFFC00000, 3};
    vecs[9]  = '{"inf_by_ninf",   32'h7F800000, 32'hFF800000, 32'hFFC00000, 3};
    vecs[10] = '{"nzero_by_1",    32'h80000000, 32'h3F800000, 32'h80000000, 3};
    vecs[11] = '{"div_4_2",       32'h40800000, 32'h40000000, 32'h40000000, 37};
    vecs[12] = '{"div_m6_2",      32'hC0C00000, 32'h40000000, 32'hC0400000, 37};
    vecs[13] = '{"one_by_nzero",  32'h3F800000, 32'h80000000, 32'hFF800000, 3};
    vecs[14] = '{"div_2_3",       32'h40000000, 32'h40400000, 32'h3F2AAAAB, 38};
    vecs[15] = '{"div_1_1",       32'h3F800000, 32'h3F800000, 32'h3F800000, 37};
`ifdef FP_DIV_DENORM_EN
    vecs[7]  = '{"min_norm_by_2", 32'h00800000, 32'h40000000, 32'h00400000, 38};
    vecs[16] = '{"denorm_by_1",   32'h00400000, 32'h3F800000, 32'h00400000, 39};
    vecs[17] = '{"one_by_denorm", 32'h3F800000, 32'h00400000, 32'h7F000000, 38};
`else
    vecs[7]  = '{"min_norm_by_2", 32'h00800000, 32'h40000000, 32'h00000000, 37};
    vecs[16] = '{"denorm_by_1",   32'h00400000, 32'h3F800000, 32'h00000000, 3};
    vecs[17] = '{"one_by_denorm", 32'h3F800000, 32'h00400000, 32'h7F800000, 3};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
    check("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
    check("rst_z", output_z, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("a_ack_after_reset", {31'd0, input_a_ack}, 32'd1);

    // Vector table
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].lat, 0);
    end

    // input_b_stb withheld: divider waits in GET_B with ack high
    exp_q.push_back(32'h40400000);
    drive_a(32'h40C00000);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!input_b_ack || output_z_stb || input_a_ack) bad++;
      @(negedge clk);
    end
    check_int("b_stall_bad_cycles", bad, 0);
    drive_b(32'h40000000, be);
    wait_result("b_stall_result", be, 37, 0);

    // output_z_ack withheld for 20 cycles with a new a offered
    run_op("backpressure", 32'h40800000, 32'h40000000, 32'h40000000, 37, 20);

    // Reset in the middle of the mantissa iterations
    drive_a(32'h40C00000);
    drive_b(32'h40000000, be);
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_a_ack", {31'd0, input_a_ack}, 32'd0);
    check("midrst_b_ack", {31'd0, input_b_ack}, 32'd0);
    check("midrst_z_stb", {31'd0, output_z_stb}, 32'd0);
    check("midrst_z", output_z, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset_4_2", 32'h40800000, 32'h40000000, 32'h40000000, 37, 0);

    check_int("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
